concat_sched: RTL

CONCAT_SCHED -- requirements
Module: concat_sched

---
 rtl/concat_pkg.sv | 14 +
 rtl/rr_arb2.sv | 26 ++
 rtl/concat_sched.sv | 82 ++++++++
 3 files changed

// File: rtl/concat_pkg.sv
// Shared defaults, output-width derivation and FSM encoding for the concat scheduler.
package concat_pkg;
  localparam int AW_DEF = 2;
  localparam int BW_DEF = 1;

  function automatic int yw(input int aw, input int bw);
    return aw + bw;
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the priority pointer moves only on a real transfer.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_xfer,
  output logic [1:0] o_gnt
);
  logic r_last;

  // On a tie, favour the requester that did not win the last transfer.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_last <= 1'b1;
    else if (i_xfer) r_last <= o_gnt[1];
  end
endmodule

// File: rtl/concat_sched.sv
// Two requesters share one {a,b} concat register; one-word output buffer with a valid/ready handshake.
module concat_sched
  import concat_pkg::*;
#(
  parameter  int AW = AW_DEF,
  parameter  int BW = BW_DEF,
  localparam int YW = yw(AW, BW)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_valid,
  input  logic [AW-1:0] r0_a,
  input  logic [BW-1:0] r0_b,
  output logic          r0_ready,
  input  logic          r1_valid,
  input  logic [AW-1:0] r1_a,
  input  logic [BW-1:0] r1_b,
  output logic          r1_ready,
  output logic          out_valid,
  output logic [YW-1:0] out_y,
  output logic          out_src,
  input  logic          out_ready,
  output logic [7:0]    out_count
);
  state_t        r_state;
  logic [YW-1:0] r_y;
  logic          r_src;
  logic [7:0]    r_count;
  logic [1:0]    w_gnt;
  logic          w_can;
  logic          w_xfer;
  logic [YW-1:0] w_word;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .i_req  ({r1_valid, r0_valid}),
    .i_xfer (w_xfer),
    .o_gnt  (w_gnt)
  );

  // The buffer can take a word when empty or when it is being drained this cycle.
  assign w_can    = reset && ((r_state == EMPTY) || out_ready);
  assign r0_ready = w_gnt[0] && w_can;
  assign r1_ready = w_gnt[1] && w_can;
  assign w_xfer   = (r0_valid && r0_ready) || (r1_valid && r1_ready);
  assign w_word   = w_gnt[1] ? {r1_a, r1_b} : {r0_a, r0_b};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= EMPTY;
      r_y     <= '0;
      r_src   <= 1'b0;
      r_count <= 8'd0;
    end else begin
      if ((r_state == FULL) && out_ready) r_count <= r_count + 8'd1;
      case (r_state)
        EMPTY: begin
          if (w_xfer) begin
            r_state <= FULL;
            r_y     <= w_word;
            r_src   <= w_gnt[1];
          end
        end
        FULL: begin
          if (w_xfer) begin
            r_y   <= w_word;
            r_src <= w_gnt[1];
          end else if (out_ready) begin
            r_state <= EMPTY;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_y     = r_y;
  assign out_src   = r_src;
  assign out_count = r_count;
endmodule
